// File: rtl/lo_div_pkg.sv
// rtl/lo_div_pkg.sv - shared defaults for the LO clock divider
package lo_div_pkg;

  localparam int LO_DIV_W     = 8;
  localparam int LO_DIV_RESET = 3;
  // One serial frame carries exactly one divisor word.
  localparam int LO_FRAME_LEN = LO_DIV_W;

endpackage

// File: rtl/input_sync.sv
// rtl/input_sync.sv - multi-flop synchronizer with registered rising-edge flag
module input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;

  // rise is registered alongside the last stage so it is aligned with level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      rise   <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];

endmodule

// File: rtl/lo_clock_divider.sv
// rtl/lo_clock_divider.sv - programmable LO divider with serially loaded divisor
module lo_clock_divider
  import lo_div_pkg::*;
#(
  parameter int DIV_W       = LO_DIV_W,
  parameter int DIV_RESET   = LO_DIV_RESET,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic ser_clk,
  input  logic ser_data,
  input  logic ser_latch,
  output logic lo_out,
  output logic div_active,
  output logic load_done
);

  logic ser_clk_rise, ser_latch_rise, ser_data_q;
  logic clk_level_unused, latch_level_unused, data_rise_unused;

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .n_rst(n_rst), .d(ser_clk),
    .level(clk_level_unused), .rise(ser_clk_rise)
  );

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .n_rst(n_rst), .d(ser_data),
    .level(ser_data_q), .rise(data_rise_unused)
  );

  input_sync #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .n_rst(n_rst), .d(ser_latch),
    .level(latch_level_unused), .rise(ser_latch_rise)
  );

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] sreg;
  logic [DIV_W-1:0] pending;
  logic             pending_valid;
  logic             terminal;
  logic             apply;

  // Running: swap divisor only at a terminal count so no half-period is cut short.
  assign terminal = (cnt == div_q);
  assign apply    = pending_valid && (!enable || terminal);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt        <= '0;
      lo_out     <= 1'b0;
      div_active <= 1'b0;
      div_q      <= DIV_W'(DIV_RESET);
    end else if (enable) begin
      div_active <= 1'b1;
      if (terminal) begin
        cnt    <= '0;
        lo_out <= ~lo_out;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (apply) div_q <= pending;
    end else begin
      cnt        <= '0;
      lo_out     <= 1'b0;
      div_active <= 1'b0;
      if (apply) div_q <= pending;
    end
  end

  // A latch coinciding with a shift captures the pre-shift word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sreg          <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      load_done <= apply;
      if (ser_clk_rise) sreg <= {sreg[DIV_W-2:0], ser_data_q};
      if (ser_latch_rise) begin
        pending       <= sreg;
        pending_valid <= 1'b1;
      end else if (apply) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lo_clock_divider.sv
// tb/tb_lo_clock_divider.sv - directed self-checking bench for lo_clock_divider
module tb_lo_clock_divider;

  logic clk = 1'b0;
  logic n_rst, enable, ser_clk, ser_data, ser_latch;
  logic lo_out, div_active, load_done;
  int total = 0;
  int bad = 0;

  lo_clock_divider #(.DIV_W(8), .DIV_RESET(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_latch(ser_latch),
    .lo_out(lo_out), .div_active(div_active), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_toggle(output int n);
    logic v;
    v = lo_out;
    n = 0;
    do begin
      tick();
      n++;
    end while (lo_out === v && n < 400);
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      ser_data = w[i];
      tick();
      ser_clk = 1'b1;
      tick(2);
      ser_clk = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset;
    int n;
    n_rst = 1'b0; enable = 1'b1; ser_clk = 1'b0; ser_data = 1'b0; ser_latch = 1'b0;
    tick(3);
    total++; if (lo_out !== 1'b0) begin bad++; $display("FAIL reset_lo_out: got %b want 0", lo_out); end
    total++; if (div_active !== 1'b0) begin bad++; $display("FAIL reset_div_active: got %b want 0", div_active); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    total++; if (dut.div_q !== 8'd3) begin bad++; $display("FAIL reset_div: got %0d want 3", dut.div_q); end
    enable = 1'b0;
    n_rst = 1'b1;
    tick();
    enable = 1'b1;
    wait_toggle(n);
    total++; if (n !== 4) begin bad++; $display("FAIL first_rise: got %0d want 4", n); end
    total++; if (lo_out !== 1'b1) begin bad++; $display("FAIL first_rise_level: got %b want 1", lo_out); end
    total++; if (div_active !== 1'b1) begin bad++; $display("FAIL div_active_run: got %b want 1", div_active); end
    wait_toggle(n);
    total++; if (n !== 4) begin bad++; $display("FAIL high_time_d3: got %0d want 4", n); end
    wait_toggle(n);
    total++; if (n !== 4) begin bad++; $display("FAIL low_time_d3: got %0d want 4", n); end
  endtask

  task automatic test_load_running;
    int n;
    logic prev;
    logic seen;
    shift_word(8'h05);
    total++; if (dut.sreg !== 8'h05) begin bad++; $display("FAIL sreg_05: got %h want 05", dut.sreg); end
    ser_latch = 1'b1;
    tick(2);
    ser_latch = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      prev = lo_out;
      tick();
      n++;
      if (load_done === 1'b1) begin
        seen = 1'b1;
        total++; if (lo_out === prev) begin bad++; $display("FAIL load_at_terminal: got lo_out %b want toggled", lo_out); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL load_done_running: got none want pulse"); end
    total++; if (dut.div_q !== 8'd5) begin bad++; $display("FAIL div_5: got %0d want 5", dut.div_q); end
    wait_toggle(n);
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL load_done_width: got %b want 0", load_done); end
    total++; if (n !== 6) begin bad++; $display("FAIL half_d5_a: got %0d want 6", n); end
    wait_toggle(n);
    total++; if (n !== 6) begin bad++; $display("FAIL half_d5_b: got %0d want 6", n); end
  endtask

  task automatic test_disable_load;
    int n;
    n = 0;
    while (lo_out !== 1'b1 && n < 50) begin tick(); n++; end
    tick(2);
    total++; if (lo_out !== 1'b1) begin bad++; $display("FAIL pre_disable_high: got %b want 1", lo_out); end
    enable = 1'b0;
    tick();
    total++; if (lo_out !== 1'b0) begin bad++; $display("FAIL disable_lo_out: got %b want 0", lo_out); end
    total++; if (div_active !== 1'b0) begin bad++; $display("FAIL disable_active: got %b want 0", div_active); end
    total++; if (dut.cnt !== 8'd0) begin bad++; $display("FAIL disable_cnt: got %0d want 0", dut.cnt); end
    shift_word(8'h00);
    ser_latch = 1'b1;
    tick(3);
    total++; if (dut.pending_valid !== 1'b1) begin bad++; $display("FAIL latch_latency: got %b want 1", dut.pending_valid); end
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL early_load: got %b want 0", load_done); end
    tick();
    total++; if (load_done !== 1'b1) begin bad++; $display("FAIL disabled_apply: got %b want 1", load_done); end
    total++; if (dut.div_q !== 8'd0) begin bad++; $display("FAIL div_0: got %0d want 0", dut.div_q); end
    total++; if (dut.pending_valid !== 1'b0) begin bad++; $display("FAIL pending_clear: got %b want 0", dut.pending_valid); end
    ser_latch = 1'b0;
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("FAIL load_pulse_one: got %b want 0", load_done); end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (lo_out !== ((i % 2) == 0)) begin bad++; $display("FAIL d0_toggle_%0d: got %b want %b", i, lo_out, (i % 2) == 0); end
    end
  endtask

  task automatic test_coincide;
    enable = 1'b0;
    tick();
    shift_word(8'hA5);
    total++; if (dut.sreg !== 8'hA5) begin bad++; $display("FAIL sreg_a5: got %h want a5", dut.sreg); end
    ser_data = 1'b0;
    ser_clk = 1'b1;
    ser_latch = 1'b1;
    tick(3);
    total++; if (dut.pending !== 8'hA5) begin bad++; $display("FAIL coincide_pending: got %h want a5", dut.pending); end
    total++; if (dut.sreg !== 8'h4A) begin bad++; $display("FAIL coincide_sreg: got %h want 4a", dut.sreg); end
    ser_clk = 1'b0;
    ser_latch = 1'b0;
    tick(2);
    total++; if (dut.div_q !== 8'hA5) begin bad++; $display("FAIL div_a5: got %h want a5", dut.div_q); end
  endtask

  task automatic test_last_wins;
    int n;
    int loads;
    logic level;
    enable = 1'b1;
    wait_toggle(n);
    total++; if (n !== 166) begin bad++; $display("FAIL half_d165: got %0d want 166", n); end
    level = lo_out;
    shift_word(8'h02);
    ser_latch = 1'b1; tick(2); ser_latch = 1'b0; tick(2);
    total++; if (dut.pending !== 8'h02) begin bad++; $display("FAIL pending_02: got %h want 02", dut.pending); end
    shift_word(8'h07);
    ser_latch = 1'b1; tick(2); ser_latch = 1'b0; tick(2);
    total++; if (dut.pending !== 8'h07) begin bad++; $display("FAIL pending_07: got %h want 07", dut.pending); end
    total++; if (lo_out !== level) begin bad++; $display("FAIL no_terminal_window: got %b want %b", lo_out, level); end
    loads = 0;
    n = 0;
    while (loads == 0 && n < 200) begin
      tick();
      n++;
      if (load_done === 1'b1) loads++;
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load_done === 1'b1) loads++;
    end
    total++; if (loads !== 1) begin bad++; $display("FAIL single_load: got %0d want 1", loads); end
    total++; if (dut.div_q !== 8'd7) begin bad++; $display("FAIL div_7: got %0d want 7", dut.div_q); end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (lo_out !== 1'b1 && n < 50) begin tick(); n++; end
    tick(2);
    #3 n_rst = 1'b0;
    #1;
    total++; if (lo_out !== 1'b0) begin bad++; $display("FAIL async_reset_lo: got %b want 0", lo_out); end
    total++; if (dut.div_q !== 8'd3) begin bad++; $display("FAIL async_reset_div: got %0d want 3", dut.div_q); end
    total++; if (dut.pending_valid !== 1'b0) begin bad++; $display("FAIL async_reset_pv: got %b want 0", dut.pending_valid); end
    #2 n_rst = 1'b1;
    wait_toggle(n);
    total++; if (n !== 4) begin bad++; $display("FAIL post_reset_rise: got %0d want 4", n); end
    wait_toggle(n);
    total++; if (n !== 4) begin bad++; $display("FAIL post_reset_half: got %0d want 4", n); end
  endtask

  initial begin
    test_reset();
    test_load_running();
    test_disable_load();
    test_coincide();
    test_last_wins();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
